// File: rtl/multi_digit_display_driver.sv
// Multiplexed multi-digit 7-segment driver: accepts a binary value over a
// valid/ready handshake, converts it to BCD by shift-and-add-3, and scans
// the resulting digits across the display with leading-zero blanking and
// an overflow indication.
module multi_digit_display_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned BIN_WIDTH      = 14,
  parameter int unsigned REFRESH_DIV    = 10000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  parameter bit          BLANK_LEADING  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 value_valid,
  input  logic [BIN_WIDTH-1:0] value,
  output logic                 value_ready,
  output logic [6:0]           segments,
  output logic [DIGITS-1:0]    display_select,
  output logic                 overflow
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(BIN_WIDTH);
  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    IDLE,
    CONVERT
  } state_e;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic [BW-1:0]        bcd_adj, bcd_shift;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic [BW-1:0]        disp_q, disp_d;
  logic                 ovf_q, ovf_d;
  logic [RW-1:0]        ref_q, ref_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [3:0]           cur_digit;
  logic                 cur_blank;
  logic                 zero_run;
  logic [6:0]           pattern;
  logic [DIGITS-1:0]    sel_onehot;

  // Add-3 correction on every BCD digit, then shift in the next binary bit.
  // A 1 leaving the top digit means the value needs more than DIGITS
  // decimal digits; that bit is accumulated as the overflow flag instead
  // of carrying wider BCD storage or a magnitude comparator.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[BW-2:0], bin_q[BIN_WIDTH-1]};
  end

  // Handshake FSM and conversion next-state; display loads only on exit.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (value_valid) begin
          state_d    = CONVERT;
          bin_d      = value;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = 1'b0;
        end
      end
      CONVERT: begin
        bin_d      = {bin_q[BIN_WIDTH-2:0], 1'b0};
        bcd_d      = bcd_shift;
        cnt_d      = cnt_q + 1'b1;
        ovf_pend_d = ovf_pend_q | bcd_adj[BW-1];
        if (cnt_q == CW'(BIN_WIDTH - 1)) begin
          state_d = IDLE;
          disp_d  = bcd_shift;
          ovf_d   = ovf_pend_q | bcd_adj[BW-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign value_ready = (state_q == IDLE);

  // Conversion and display state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
    end
  end

  // Refresh prescaler and digit index, free-running and independent of conversion.
  always_comb begin
    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Refresh scan registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_q <= '0;
      idx_q <= '0;
    end else begin
      ref_q <= ref_d;
      idx_q <= idx_d;
    end
  end

  // Select the active digit and decide blanking, walking from the most
  // significant digit down so zero_run covers the digit and all above it.
  always_comb begin
    cur_digit  = '0;
    cur_blank  = 1'b0;
    zero_run   = 1'b1;
    sel_onehot = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      zero_run = zero_run & (disp_q[(DIGITS-1-i)*4 +: 4] == 4'd0);
      if (idx_q == IW'(DIGITS - 1 - i)) begin
        cur_digit = disp_q[(DIGITS-1-i)*4 +: 4];
        cur_blank = zero_run && ((DIGITS - 1 - i) != 0);
      end
      sel_onehot[i] = (idx_q == IW'(i));
    end
  end

  // Segment decode with dash on overflow and polarity applied last.
  always_comb begin
    pattern = 7'b0000000;
    if (ovf_q) begin
      pattern = 7'b0000001;
    end else if (BLANK_LEADING && cur_blank) begin
      pattern = 7'b0000000;
    end else begin
      unique case (cur_digit)
        4'd0:    pattern = 7'b1111110;
        4'd1:    pattern = 7'b0110000;
        4'd2:    pattern = 7'b1101101;
        4'd3:    pattern = 7'b1111001;
        4'd4:    pattern = 7'b0110011;
        4'd5:    pattern = 7'b1011011;
        4'd6:    pattern = 7'b1011111;
        4'd7:    pattern = 7'b1110000;
        4'd8:    pattern = 7'b1111111;
        4'd9:    pattern = 7'b1110011;
        default: pattern = 7'b0000000;
      endcase
    end
    segments       = SEG_ACTIVE_LOW ? ~pattern : pattern;
    display_select = SEL_ACTIVE_LOW ? ~sel_onehot : sel_onehot;
    overflow       = ovf_q;
  end

endmodule

// File: tb/tb_multi_digit_display_driver.sv
// Scoreboard bench for multi_digit_display_driver: four instances with
// different digit counts and polarities share one stimulus stream.
module tb_multi_digit_display_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        value_valid = 1'b0;
  logic [13:0] value = '0;

  logic       rdy [4];
  logic       ovf [4];
  logic [6:0] s0, s1, s2, s3;
  logic [3:0] d0, d1, d3;
  logic [2:0] d2;
  logic [7:0] seg_a [4];
  logic [7:0] sel_a [4];

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_q[$];
  int unsigned prev_val = 0;
  int unsigned cyc = 0;

  int cfg_digits [4] = '{4, 4, 3, 4};
  bit cfg_bl     [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit cfg_seglow [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  bit cfg_sellow [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  assign seg_a[0] = {1'b0, s0};
  assign seg_a[1] = {1'b0, s1};
  assign seg_a[2] = {1'b0, s2};
  assign seg_a[3] = {1'b0, s3};
  assign sel_a[0] = {4'b0, d0};
  assign sel_a[1] = {4'b0, d1};
  assign sel_a[2] = {5'b0, d2};
  assign sel_a[3] = {4'b0, d3};

  multi_digit_display_driver #(.DIGITS(4), .BIN_WIDTH(14), .REFRESH_DIV(4)) u_dut0 (
    .clk(clk), .reset(reset), .value_valid(value_valid), .value(value),
    .value_ready(rdy[0]), .segments(s0), .display_select(d0), .overflow(ovf[0]));

  multi_digit_display_driver #(.DIGITS(4), .BIN_WIDTH(14), .REFRESH_DIV(4),
                               .BLANK_LEADING(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .value_valid(value_valid), .value(value),
    .value_ready(rdy[1]), .segments(s1), .display_select(d1), .overflow(ovf[1]));

  multi_digit_display_driver #(.DIGITS(3), .BIN_WIDTH(14), .REFRESH_DIV(4)) u_dut2 (
    .clk(clk), .reset(reset), .value_valid(value_valid), .value(value),
    .value_ready(rdy[2]), .segments(s2), .display_select(d2), .overflow(ovf[2]));

  multi_digit_display_driver #(.DIGITS(4), .BIN_WIDTH(14), .REFRESH_DIV(4),
                               .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b0)) u_dut3 (
    .clk(clk), .reset(reset), .value_valid(value_valid), .value(value),
    .value_ready(rdy[3]), .segments(s3), .display_select(d3), .overflow(ovf[3]));

  always #5 clk = ~clk;

  // Edges since reset release; the scan model derives the active slot from it.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic bit ovf_model(input int unsigned v, input int d);
    longint unsigned lim;
    lim = 1;
    for (int i = 0; i < cfg_digits[d]; i++) lim = lim * 10;
    return (longint'(v) > lim - 1);
  endfunction

  function automatic logic [7:0] seg_model(input int unsigned v, input int d, input int slot);
    longint unsigned pw;
    longint unsigned q;
    logic [6:0] pat;
    pat = 7'b0000000;
    if (ovf_model(v, d)) begin
      pat = 7'b0000001;
    end else begin
      pw = 1;
      for (int i = 0; i < slot; i++) pw = pw * 10;
      q = longint'(v) / pw;
      if (cfg_bl[d] && slot != 0 && q == 0) begin
        pat = 7'b0000000;
      end else begin
        case (q % 10)
          0: pat = 7'b1111110;
          1: pat = 7'b0110000;
          2: pat = 7'b1101101;
          3: pat = 7'b1111001;
          4: pat = 7'b0110011;
          5: pat = 7'b1011011;
          6: pat = 7'b1011111;
          7: pat = 7'b1110000;
          8: pat = 7'b1111111;
          default: pat = 7'b1110011;
        endcase
      end
    end
    if (cfg_seglow[d]) pat = ~pat;
    return {1'b0, pat};
  endfunction

  function automatic logic [7:0] sel_model(input int d, input int slot);
    logic [7:0] s;
    s = 8'd1 << slot;
    if (cfg_sellow[d]) s = ~s;
    s = s & ((8'd1 << cfg_digits[d]) - 8'd1);
    return s;
  endfunction

  task automatic scan_display(input int unsigned v, input int unsigned cycles);
    for (int unsigned c = 0; c < cycles; c++) begin
      for (int d = 0; d < 4; d++) begin
        int slot;
        slot = int'((cyc / 4) % cfg_digits[d]);
        checks++;
        if (sel_a[d] !== sel_model(d, slot)) begin
          errors++;
          $display("FAIL scan_select dut%0d cyc%0d: got %b expected %b", d, cyc, sel_a[d], sel_model(d, slot));
        end
        checks++;
        if (seg_a[d] !== seg_model(v, d, slot)) begin
          errors++;
          $display("FAIL scan_segments dut%0d value %0d slot %0d: got %b expected %b", d, v, slot, seg_a[d][6:0], seg_model(v, d, slot));
        end
        checks++;
        if (ovf[d] !== ovf_model(v, d)) begin
          errors++;
          $display("FAIL scan_overflow dut%0d value %0d: got %b expected %b", d, v, ovf[d], ovf_model(v, d));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic convert_value(input int unsigned v, input bit junk, input bit scan);
    int unsigned got;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (rdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL ready_idle dut%0d: got %b expected 1", d, rdy[d]);
      end
    end
    value       = 14'(v);
    value_valid = 1'b1;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    value_valid = 1'b0;
    value       = 14'(v) ^ 14'h2AAA;
    for (int i = 0; i < 14; i++) begin
      if (junk && i == 3) begin
        value_valid = 1'b1;
        value       = 14'd55;
      end
      if (junk && i == 7) value_valid = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (rdy[d] !== 1'b0) begin
          errors++;
          $display("FAIL ready_busy dut%0d cycle %0d: got %b expected 0", d, i, rdy[d]);
        end
        if (i == 13) begin
          int slot;
          slot = int'((cyc / 4) % cfg_digits[d]);
          checks++;
          if (seg_a[d] !== seg_model(prev_val, d, slot) || ovf[d] !== ovf_model(prev_val, d)) begin
            errors++;
            $display("FAIL display_held dut%0d: got %b/%b expected %b/%b", d, seg_a[d][6:0], ovf[d], seg_model(prev_val, d, slot), ovf_model(prev_val, d));
          end
        end
      end
    end
    @(negedge clk);
    got = exp_q.pop_front();
    for (int d = 0; d < 4; d++) begin
      int slot;
      slot = int'((cyc / 4) % cfg_digits[d]);
      checks++;
      if (rdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL ready_done dut%0d: got %b expected 1", d, rdy[d]);
      end
      checks++;
      if (seg_a[d] !== seg_model(got, d, slot) || ovf[d] !== ovf_model(got, d)) begin
        errors++;
        $display("FAIL display_update dut%0d value %0d: got %b/%b expected %b/%b", d, got, seg_a[d][6:0], ovf[d], seg_model(got, d, slot), ovf_model(got, d));
      end
    end
    prev_val = got;
    if (scan) scan_display(got, 16);
  endtask

  task automatic test_reset;
    #2;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (rdy[d] !== 1'b1 || ovf[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags dut%0d: got ready %b ovf %b expected 1 0", d, rdy[d], ovf[d]);
      end
      checks++;
      if (sel_a[d] !== sel_model(d, 0) || seg_a[d] !== seg_model(0, d, 0)) begin
        errors++;
        $display("FAIL reset_display dut%0d: got %b/%b expected %b/%b", d, sel_a[d], seg_a[d][6:0], sel_model(d, 0), seg_model(0, d, 0));
      end
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_refresh;
    scan_display(0, 16);
  endtask

  task automatic test_convert;
    convert_value(1234, 1'b0, 1'b1);
  endtask

  task automatic test_blanking;
    convert_value(7, 1'b0, 1'b1);
  endtask

  task automatic test_overflow;
    convert_value(12000, 1'b0, 1'b1);
    convert_value(9999, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    convert_value(42, 1'b0, 1'b0);
    convert_value(8, 1'b0, 1'b1);
  endtask

  task automatic test_ignore_during_convert;
    convert_value(300, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_convert;
    value       = 14'd4321;
    value_valid = 1'b1;
    exp_q.push_back(4321);
    @(posedge clk);
    #1;
    value_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (rdy[d] !== 1'b1 || ovf[d] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_flags dut%0d: got ready %b ovf %b expected 1 0", d, rdy[d], ovf[d]);
      end
      checks++;
      if (sel_a[d] !== sel_model(d, 0) || seg_a[d] !== seg_model(0, d, 0)) begin
        errors++;
        $display("FAIL midreset_display dut%0d: got %b/%b expected %b/%b", d, sel_a[d], seg_a[d][6:0], sel_model(d, 0), seg_model(0, d, 0));
      end
    end
    exp_q.delete();
    prev_val = 0;
    @(negedge clk);
    reset = 1'b1;
    scan_display(0, 16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_refresh;
    test_convert;
    test_blanking;
    test_overflow;
    test_back_to_back;
    test_ignore_during_convert;
    test_reset_mid_convert;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
